pc_fetch_sequencer: RTL
=======================

# pc_fetch_sequencer

Multi-cycle instruction-fetch and PC-update controller for the single-issue RISC-V datapath. It owns the program counter, fetches one instruction at a time over a req/ack instruction-memory handshake, and issues it to decode with a valid/ready handshake. It waits for the ALU branch resolution, then selects PC+4 or the branch target (taken when `branch & zero`). It also counts retired instructions and halts permanently on a misaligned branch target.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request; held high until `imem_ack`.
- `imem_addr`  out  32  fetch address; equals `pc` whenever `imem_req` is high.
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  captured instruction word to decode.
- `instr_valid`  out  1  `instr` is offered to decode.
- `instr_ready`  in  1  decode accepts `instr`.
- `resolve_valid`  in  1  the datapath has resolved the current instruction.
- `branch`  in  1  control-unit branch signal; sampled only with `resolve_valid`.
- `zero`  in  1  ALU zero flag; sampled only with `resolve_valid`.
- `branch_target`  in  32  PC-relative target (PC + shifted immediate).
- `pc`  out  32  PC of the instruction in flight.
- `retired`  out  32  count of resolved instructions; wraps modulo 2^32.
- `halted`  out  1  sticky misaligned-target error.

## Operation
- States:
  - IDLE → REQ unconditionally.
  - REQ → ISSUE on `imem_ack`.
  - ISSUE → EXEC on `instr_ready`.
  - EXEC → REQ on `resolve_valid` with an aligned next PC.
  - EXEC → HALT on `resolve_valid` with a misaligned next PC.
  - HALT is terminal until reset.
- REQ: `imem_req`=1. On `imem_ack`, capture `imem_rdata` into `instr`.
- ISSUE: `instr_valid`=1. `instr` is stable until accepted.
- EXEC: on `resolve_valid`:
  - next = (`branch & zero`) ? `branch_target` : `pc + 4`.
  - `retired` increments by 1.
  - If next[1:0] ≠ 0: `pc` is unchanged, `halted` is set, enter HALT.
  - Otherwise `pc` ← next.
- A misaligned target is checked only when the branch is taken. `pc + 4` is always aligned.
- PC arithmetic is 32-bit unsigned with wrap: 0xFFFF_FFFC + 4 = 0x0000_0000.
- Ignored inputs:
  - `imem_ack` outside REQ.
  - `instr_ready` outside ISSUE.
  - `resolve_valid` outside EXEC.
  - `branch`/`zero`/`branch_target` when `resolve_valid` is low.
- HALT: `imem_req`=0, `instr_valid`=0, and all inputs are ignored.

## Timing
- Reset asserted (asynchronous), all outputs take their reset values immediately:
  - state = IDLE, `pc`=`RESET_PC`, `instr`=0, `retired`=0.
  - `imem_req`=0, `instr_valid`=0, `halted`=0.
- First `imem_req` is high in the 2nd cycle after reset deasserts (IDLE lasts one cycle).
- `imem_ack` in the first REQ cycle: `instr_valid` is high the next cycle (zero-wait fetch).
- Minimum throughput: 3 cycles per instruction (REQ, ISSUE, EXEC), with `imem_ack`, `instr_ready` and `resolve_valid` each high on first opportunity.
- Updated `pc` is visible in the cycle after `resolve_valid` and drives `imem_addr` in that same cycle.
- Reset mid-operation: any in-flight fetch is abandoned and `imem_req` drops asynchronously. Memory must tolerate an abandoned request.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Package `pc_seq_pkg`:
  - state enum `pc_seq_state_t` (IDLE, REQ, ISSUE, EXEC, HALT).
  - constants `INSTR_BYTES`=4 and `PC_WIDTH`=32.
- One sub-module, `pc_next_select` (combinational): inputs `pc`, `branch_target`, `branch`, `zero`; outputs the next PC and a `misaligned` flag.
- Top level holds the FSM, the `pc`/`instr`/`retired`/`halted` registers and the handshake decode.

## Test plan
- Reset, then `imem_ack` high in every cycle, `instr_ready` high, `resolve_valid` with `branch`=0 → `imem_addr` sequence 0x0, 0x4, 0x8. Each request arrives 3 cycles apart. `retired`=3 after the third resolve.
- `branch`=1, `zero`=1, `branch_target`=0x100 → next `imem_addr`=0x100. `branch`=1, `zero`=0 → next `imem_addr`=`pc`+4.
- `imem_ack` delayed 4 cycles and `instr_ready` delayed 2 cycles → `imem_req` held 5 cycles with `imem_addr` stable. `instr` stable while `instr_valid` and not ready. Spurious early `resolve_valid` pulses are ignored.
- `RESET_PC`=0xFFFF_FFFC, not-taken resolve → `pc`=0x0. `retired` preset near 0xFFFF_FFFF via a long run or force → wraps to 0.
- Taken branch to 0x102 → `halted`=1 next cycle, `pc` unchanged, `imem_req` stays 0 for 10 cycles.
- Assert `reset` while in REQ and while in HALT → `imem_req`=0 and `halted`=0 immediately. Fetch restarts at `RESET_PC` in the 2nd cycle after release.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the instruction-fetch / PC-update sequencer.
package pc_seq_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int PC_WIDTH    = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } pc_seq_state_t;

endpackage

// File: rtl/pc_next_select.sv
// Next-PC selection: sequential PC+4 or taken-branch target, with target alignment check.
module pc_next_select
  import pc_seq_pkg::*;
(
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                branch,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                misaligned
);

  logic w_taken;

  assign w_taken = branch & zero;
  assign next_pc = w_taken ? branch_target : (pc + PC_WIDTH'(INSTR_BYTES));
  // PC+4 from an aligned PC is always aligned, so only a taken target can fault.
  assign misaligned = w_taken & (|branch_target[1:0]);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, fetches over req/ack, issues over
// valid/ready, waits for branch resolution, counts retirements, halts on a bad target.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        resolve_valid,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  // Handshakes: imem_req stays high until imem_ack is seen in the same cycle;
  // instr_valid stays high with instr stable until instr_ready is seen; a
  // transfer happens on any rising clock edge where both sides are high.

  pc_seq_state_t r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [31:0]   r_retired;
  logic          r_halted;

  logic [31:0]   w_next_pc;
  logic          w_misaligned;

  pc_next_select u_next (
    .pc            (r_pc),
    .branch_target (branch_target),
    .branch        (branch),
    .zero          (zero),
    .next_pc       (w_next_pc),
    .misaligned    (w_misaligned)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= 32'h0;
      r_retired <= 32'h0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) r_state <= EXEC;
        end
        EXEC: begin
          if (resolve_valid) begin
            r_retired <= r_retired + 32'd1;
            // A faulting instruction still retires, but the PC stays on it.
            if (w_misaligned) begin
              r_halted <= 1'b1;
              r_state  <= HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= REQ;
            end
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs come only from registers or state decode.
  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ISSUE);
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign retired     = r_retired;
  assign halted      = r_halted;
  assign dbg_state   = r_state;

endmodule
